// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: state encoding and default sizing for the frequency measurement controller
package freq_meas_pkg;
  typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, DONE} state_t;
  localparam int CNT_W_DEF   = 32;
  localparam int GATE_DEF    = 50_000_000;
  localparam int TIMEOUT_DEF = 100_000_000;
  localparam int SYNC_DEF    = 2;
endpackage

// File: rtl/freq_meas_ctrl_fx_edge_sync.sv
// fx_edge_sync: brings clk_fx into the sys_clk domain and flags its rising edges
module fx_edge_sync import freq_meas_pkg::*; #(
  parameter int STAGES = SYNC_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clk_fx,
  output logic fx_sync,
  output logic fx_rise
);
  logic [STAGES:0] sr;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) sr <= '0;
    else sr <= {sr[STAGES-1:0], clk_fx};
  assign fx_sync = sr[STAGES-1];
  assign fx_rise = sr[STAGES-1] & ~sr[STAGES];
endmodule

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: sequences one equal-precision measurement of clk_fx and hands raw counts downstream
module freq_meas_ctrl import freq_meas_pkg::*; #(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int GATE_CYCLES    = GATE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int SYNC_STAGES    = SYNC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clk_fx,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic             busy,
  output logic             gate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_fx_cnt,
  output logic [CNT_W-1:0] res_ref_cnt,
  output logic [CNT_W-1:0] res_high_cnt,
  output logic             res_timeout,
  output logic             res_ovf
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] GATE_T = CNT_W'(GATE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic fx_sync, fx_rise, ovf, full, closing, tmo_hit;
  logic [CNT_W-1:0] t, fx_cnt, high_cnt;
  logic [TW-1:0] tmo;
  fx_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clk_fx(clk_fx),
    .fx_sync(fx_sync),
    .fx_rise(fx_rise)
  );
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction
  assign full    = t >= GATE_T;
  assign closing = fx_rise && full;
  assign tmo_hit = tmo == TMO_LAST;
  assign busy    = state != IDLE;
  // t counts cycles since the opening rise, so the opening cycle itself is t=0
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state        <= IDLE;
      gate         <= 1'b0;
      res_valid    <= 1'b0;
      res_fx_cnt   <= '0;
      res_ref_cnt  <= '0;
      res_high_cnt <= '0;
      res_timeout  <= 1'b0;
      res_ovf      <= 1'b0;
      t            <= '0;
      fx_cnt       <= '0;
      high_cnt     <= '0;
      ovf          <= 1'b0;
      tmo          <= '0;
    end else if (abort) begin
      state     <= IDLE;
      gate      <= 1'b0;
      res_valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= ARM;
            tmo   <= '0;
          end
        ARM:
          if (fx_rise) begin
            state    <= GATE;
            gate     <= 1'b1;
            t        <= CNT_W'(1);
            fx_cnt   <= '0;
            high_cnt <= CNT_W'(1);
            ovf      <= 1'b0;
          end else if (tmo_hit) begin
            state        <= DONE;
            res_valid    <= 1'b1;
            res_timeout  <= 1'b1;
            res_fx_cnt   <= '0;
            res_ref_cnt  <= '0;
            res_high_cnt <= '0;
            res_ovf      <= 1'b0;
          end else tmo <= tmo + TW'(1);
        GATE, CLOSE: begin
          t        <= sat_inc(t, 1'b1);
          fx_cnt   <= sat_inc(fx_cnt, fx_rise);
          high_cnt <= sat_inc(high_cnt, fx_sync);
          ovf      <= ovf | (&t) | (fx_rise & (&fx_cnt)) | (fx_sync & (&high_cnt));
          tmo      <= state == GATE ? '0 : tmo + TW'(1);
          if (closing || (state == CLOSE && tmo_hit)) begin
            state        <= DONE;
            gate         <= 1'b0;
            res_valid    <= 1'b1;
            res_timeout  <= !closing;
            res_fx_cnt   <= sat_inc(fx_cnt, fx_rise);
            res_ref_cnt  <= t;
            res_high_cnt <= high_cnt;
            res_ovf      <= ovf | (fx_rise & (&fx_cnt));
          end else if (state == GATE && full) state <= CLOSE;
        end
        DONE:
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= continuous ? ARM : IDLE;
            tmo       <= '0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed and randomized checks of freq_meas_ctrl against a sample-level model
`timescale 1ns/100ps
module tb_freq_meas_ctrl;
  localparam int G = 100, T = 1000, S = 2;
  logic sys_clk = 0, sys_rst = 1, clk_fx = 0, start = 0, continuous = 0, abort = 0, res_ready = 0;
  logic busy, gate, res_valid, res_timeout, res_ovf;
  logic [31:0] res_fx_cnt, res_ref_cnt, res_high_cnt;
  int total = 0, bad = 0, cyc = 0, rst_cyc = 0, P = 200, H = 60;
  bit fx_on = 1;
  bit s [65536];
  bit g [65536];
  freq_meas_ctrl #(.CNT_W(32), .GATE_CYCLES(G), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_fx(clk_fx), .start(start),
    .continuous(continuous), .abort(abort), .busy(busy), .gate(gate),
    .res_valid(res_valid), .res_ready(res_ready), .res_fx_cnt(res_fx_cnt),
    .res_ref_cnt(res_ref_cnt), .res_high_cnt(res_high_cnt),
    .res_timeout(res_timeout), .res_ovf(res_ovf)
  );
  always #10 sys_clk = ~sys_clk;
  // fx edges sit on half-ns points so they never coincide with a sys_clk edge
  initial begin
    #0.5;
    forever if (fx_on) begin clk_fx = 1; #(H); clk_fx = 0; #(P - H); end else #1;
  end
  always @(posedge sys_clk) begin s[cyc] = clk_fx; cyc++; end
  always @(negedge sys_clk) g[cyc - 1] = gate;
  function automatic logic sy(input int n);
    return (n - S >= rst_cyc) ? s[n - S] : 1'b0;
  endfunction
  function automatic logic rs(input int n);
    return sy(n) & ~sy(n - 1);
  endfunction
  function automatic void predict(input int ns, output int o, output int c, output int fx,
                                  output int rf, output int hi, output logic to);
    o = -1; c = -1; fx = 0; rf = 0; hi = 0; to = 0;
    for (int n = ns + 1; n <= ns + T && o < 0; n++) if (rs(n)) o = n;
    if (o < 0) begin c = ns + T; to = 1; return; end
    for (int n = o + G; n <= o + G + T && c < 0; n++) if (rs(n)) c = n;
    to = c < 0;
    if (to) c = o + G + T;
    for (int n = o + 1; n <= c; n++) fx += int'(rs(n));
    for (int n = o; n < c; n++) hi += int'(sy(n));
    rf = c - o;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic pulse_start(output int ns);
    start = 1; ns = cyc; tick(1); start = 0;
  endtask
  task automatic accept(output int a);
    res_ready = 1; a = cyc; tick(1); res_ready = 0;
  endtask
  task automatic run_check(input string tag, input int ns, output int fx, output int rf, output int hi);
    int o, c, k, gl;
    logic to;
    k = 0;
    while (!res_valid && k < 3000) begin tick(1); k++; end
    check({tag, ".valid"}, 32'(res_valid), 1);
    predict(ns, o, c, fx, rf, hi, to);
    check({tag, ".cyc"}, cyc - 1, c);
    check({tag, ".fx"}, res_fx_cnt, fx);
    check({tag, ".ref"}, res_ref_cnt, rf);
    check({tag, ".high"}, res_high_cnt, hi);
    check({tag, ".tmo"}, 32'(res_timeout), 32'(to));
    check({tag, ".ovf"}, 32'(res_ovf), 0);
    check({tag, ".closed"}, 32'(gate), 0);
    if (o >= 0) begin
      gl = 0;
      for (int n = ns; n < c; n++) gl += int'(g[n]);
      check({tag, ".gatelen"}, gl, c - o);
      check({tag, ".open"}, 32'(g[o]), 1);
    end
  endtask
  initial begin
    int ns, a, fx, rf, hi, k, d;
    tick(1);
    check("rst.flags", {27'b0, busy, gate, res_valid, res_timeout, res_ovf}, 0);
    check("rst.cnts", res_fx_cnt | res_ref_cnt | res_high_cnt, 0);
    sys_rst = 0; rst_cyc = cyc;
    tick(20);
    pulse_start(ns);
    run_check("t1", ns, fx, rf, hi);
    check("t1.fx10", res_fx_cnt, 10);
    check("t1.ref100", res_ref_cnt, 100);
    check("t1.high30", res_high_cnt, 30);
    accept(a);
    check("t1.idle", 32'(busy), 0);
    P = 30; H = 15; tick(20);
    pulse_start(ns);
    run_check("t2", ns, fx, rf, hi);
    accept(a);
    for (int i = 0; i < 6; i++) begin
      P = $urandom_range(300, 41);
      H = $urandom_range(P - 20, 20);
      tick(20 + $urandom_range(15, 0));
      pulse_start(ns);
      run_check("rnd", ns, fx, rf, hi);
      d = fx * P - rf * 20;
      check("rnd.accuracy", 32'(d < P && d > -P), 1);
      accept(a);
      check("rnd.idle", 32'(busy), 0);
    end
    fx_on = 0; tick(30);
    pulse_start(ns);
    run_check("arm_tmo", ns, fx, rf, hi);
    check("arm_tmo.flag", 32'(res_timeout), 1);
    check("arm_tmo.cnt", res_fx_cnt | res_ref_cnt | res_high_cnt, 0);
    accept(a);
    fx_on = 1; P = 200; H = 60; tick(20);
    pulse_start(ns);
    tick(50); fx_on = 0;
    run_check("close_tmo", ns, fx, rf, hi);
    check("close_tmo.flag", 32'(res_timeout), 1);
    accept(a);
    fx_on = 1; tick(20);
    continuous = 1;
    pulse_start(ns);
    run_check("cont1", ns, fx, rf, hi);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      start = i == 10;
      tick(1);
      k += int'(res_valid && !gate && res_fx_cnt == fx && res_ref_cnt == rf && res_high_cnt == hi);
    end
    start = 0;
    check("cont.hold", k, 50);
    accept(a);
    check("cont.drop", 32'(res_valid), 0);
    run_check("cont2", a, fx, rf, hi);
    continuous = 0;
    accept(a);
    check("cont.idle", 32'(busy), 0);
    tick(20);
    pulse_start(ns);
    tick(40);
    check("ab.gate_on", 32'(gate), 1);
    abort = 1; start = 1; tick(1); abort = 0; start = 0;
    check("ab.flags", {29'b0, busy, gate, res_valid}, 0);
    k = 0;
    repeat (200) begin tick(1); k += int'(res_valid | busy); end
    check("ab.quiet", k, 0);
    abort = 1; start = 1; tick(1); abort = 0; start = 0;
    check("ab.idle_start", 32'(busy), 0);
    tick(10);
    pulse_start(ns);
    tick(50); fx_on = 0; tick(100);
    check("rst6.busy", 32'(busy), 1);
    #3 sys_rst = 1;
    #1 check("rst6.flags", {27'b0, busy, gate, res_valid, res_timeout, res_ovf}, 0);
    check("rst6.cnts", res_fx_cnt | res_ref_cnt | res_high_cnt, 0);
    tick(2);
    sys_rst = 0; rst_cyc = cyc;
    fx_on = 1; tick(20);
    pulse_start(ns);
    run_check("t6", ns, fx, rf, hi);
    check("t6.fx10", res_fx_cnt, 10);
    check("t6.ref100", res_ref_cnt, 100);
    check("t6.high30", res_high_cnt, 30);
    accept(a);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
